// File: rtl/motor_pwm_slave.sv
// Avalon-MM register slave driving one H-bridge channel with shadowed PWM,
// direction/decay selection and dead-time insertion on direction or run changes.
module motor_pwm_slave #(
    parameter int unsigned DEAD_CYCLES = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_cs,
    input  logic [3:0]  s_address,
    input  logic        s_write,
    input  logic        s_read,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        s_waitrequest,
    output logic        motor_in1,
    output logic        motor_in2
);

    typedef enum logic [1:0] {StIdle, StDead, StRun} state_e;

    localparam logic [CNT_W-1:0] CntOne   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       DeadInit = 8'(DEAD_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             go_q, go_d;
    logic             fwd_q, fwd_d;
    logic             fast_q, fast_d;
    logic [CNT_W-1:0] act_total_q, act_total_d;
    logic [CNT_W-1:0] act_high_q, act_high_d;
    logic             act_fast_q, act_fast_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       dead_q, dead_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rd_done_q, rd_done_d;
    logic             in1_q, in1_d;
    logic             in2_q, in2_d;

    logic        wr_en;
    logic        rd_en;
    logic        ctrl_wr;
    logic        last;
    logic        pwm;
    logic        pending;
    logic [31:0] status;

    assign wr_en   = s_cs & s_write;
    // A simultaneous write takes the bus cycle; the read is dropped.
    assign rd_en   = s_cs & s_read & ~s_write;
    assign ctrl_wr = wr_en && (s_address == 4'd2);

    assign s_waitrequest = rd_en & ~rd_done_q;
    assign s_readdata    = rdata_q;
    assign motor_in1     = in1_q;
    assign motor_in2     = in2_q;

    assign last    = (act_total_q == '0) || (cnt_q == act_total_q - CntOne);
    assign pwm     = (act_total_q != '0) && (cnt_q < act_high_q);
    assign pending = (total_q != act_total_q) || (high_q != act_high_q) ||
                     (fast_q != act_fast_q);
    assign status  = {29'b0, state_q == StDead, pending, state_q == StRun};

    always_comb begin
        total_d = total_q;
        high_d  = high_q;
        go_d    = go_q;
        fwd_d   = fwd_q;
        fast_d  = fast_q;
        if (wr_en) begin
            unique case (s_address)
                4'd0:    total_d = s_writedata[CNT_W-1:0];
                4'd1:    high_d  = s_writedata[CNT_W-1:0];
                4'd2: begin
                    go_d   = s_writedata[0];
                    fwd_d  = s_writedata[1];
                    fast_d = s_writedata[2];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_done_d = s_waitrequest;
        rdata_d   = rdata_q;
        if (s_waitrequest) begin
            unique case (s_address)
                4'd0:    rdata_d = 32'(total_q);
                4'd1:    rdata_d = 32'(high_q);
                4'd2:    rdata_d = {29'b0, fast_q, fwd_q, go_q};
                4'd3:    rdata_d = status;
                default: rdata_d = '0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        dead_d  = dead_q;
        dir_d   = dir_q;
        cnt_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (go_q) begin
                    state_d = StDead;
                    dead_d  = DeadInit;
                end
            end
            StDead: begin
                if (ctrl_wr && ((s_writedata[0] != go_q) || (s_writedata[1] != fwd_q))) begin
                    dead_d = DeadInit;
                end else if (dead_q <= 8'd1) begin
                    dead_d = '0;
                    if (go_q) begin
                        state_d = StRun;
                        dir_d   = fwd_q;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    dead_d = dead_q - 8'd1;
                end
            end
            StRun: begin
                if (!go_q || (fwd_q != dir_q)) begin
                    state_d = StDead;
                    dead_d  = DeadInit;
                end else begin
                    cnt_d = last ? '0 : cnt_q + CntOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Shadows only move at a period boundary so a running period is never torn.
    always_comb begin
        act_total_d = act_total_q;
        act_high_d  = act_high_q;
        act_fast_d  = act_fast_q;
        if ((state_q != StRun) || last) begin
            act_total_d = total_q;
            act_high_d  = high_q;
            act_fast_d  = fast_q;
        end
    end

    // A zero period coasts the bridge regardless of decay mode.
    always_comb begin
        in1_d = 1'b0;
        in2_d = 1'b0;
        if ((state_q == StRun) && (act_total_q != '0)) begin
            unique case ({dir_q, act_fast_q})
                2'b11: in1_d = pwm;
                2'b10: begin
                    in1_d = 1'b1;
                    in2_d = ~pwm;
                end
                2'b01: in2_d = pwm;
                2'b00: begin
                    in1_d = ~pwm;
                    in2_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            total_q     <= '0;
            high_q      <= '0;
            go_q        <= 1'b0;
            fwd_q       <= 1'b0;
            fast_q      <= 1'b0;
            act_total_q <= '0;
            act_high_q  <= '0;
            act_fast_q  <= 1'b0;
            dir_q       <= 1'b0;
            cnt_q       <= '0;
            dead_q      <= '0;
            rdata_q     <= '0;
            rd_done_q   <= 1'b0;
            in1_q       <= 1'b0;
            in2_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            high_q      <= high_d;
            go_q        <= go_d;
            fwd_q       <= fwd_d;
            fast_q      <= fast_d;
            act_total_q <= act_total_d;
            act_high_q  <= act_high_d;
            act_fast_q  <= act_fast_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            dead_q      <= dead_d;
            rdata_q     <= rdata_d;
            rd_done_q   <= rd_done_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
        end
    end

endmodule
